hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Generates stall, flush and forwarding selects for the IF/ID, ID/EX and EX/MEM pipeline registers from the register fields and control bits of instructions in flight.
- Owns the multi-cycle MULT/DIV sequencer: tracks occupancy of the HI/LO unit and issues its write-back strobe.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/md_sequencer.sv | 79 +++++++
 rtl/hazard_ctrl.sv | 68 ++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Package     : mips_pkg
// Description : Shared constants, MD sequencer state encoding and the
//               operand-bypass helper for the MIPS hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    // E-stage ALU operand source select
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Register $0 is hard-wired and never a bypass source
    localparam logic [4:0] REG_ZERO = 5'd0;

    // HI/LO multi-cycle sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Operand select for one E-stage source; the younger M result wins over W
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       regwrite_m,
        input logic [4:0] writereg_m,
        input logic       regwrite_w,
        input logic [4:0] writereg_w
    );
        if (src != REG_ZERO && regwrite_m && writereg_m == src)
            return FWD_M;
        else if (src != REG_ZERO && regwrite_w && writereg_w == src)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Interface   : hazard_ctrl_if
// Description : Pipeline-to-hazard-controller signal bundle. The pipeline
//               (master) drives register fields and control bits; the
//               controller (slave) returns stall/flush/forward and HI/LO status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;

    logic [4:0] rsD, rtD, rsE, rtE;
    logic       branchD, md_useD;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM;
    logic       md_startE, md_divE;

    logic       stallF, stallD, flushE;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       md_busy, hilo_we;

    modport master (
        output rsD, rtD, rsE, rtE, branchD, md_useD,
               writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW,
               memtoregE, memtoregM, md_startE, md_divE,
        input  stallF, stallD, flushE, forwardAD, forwardBD,
               forwardAE, forwardBE, md_busy, hilo_we
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, branchD, md_useD,
               writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW,
               memtoregE, memtoregM, md_startE, md_divE,
        output stallF, stallD, flushE, forwardAD, forwardBD,
               forwardAE, forwardBE, md_busy, hilo_we
    );

endinterface

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
// Module      : md_sequencer
// Description : MULT/DIV occupancy tracker. A start in cycle T raises md_busy
//               for T+1..T+N and pulses hilo_we in cycle T+N.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic md_start_i,
    input  wire logic md_div_i,
    output logic      md_busy_o,
    output logic      hilo_we_o
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             hilo_we_q;

    // Sequencer FSM with registered busy/strobe; counter loads only in IDLE
    // and moves to DONE on the cycle it would reach zero, which lands the
    // strobe exactly N cycles after the start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hilo_we_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    busy_q    <= 1'b0;
                    hilo_we_q <= 1'b0;
                    if (md_start_i) begin
                        cnt_q   <= md_div_i ? CNT_W'(DIV_CYCLES - 1)
                                            : CNT_W'(MULT_CYCLES - 1);
                        busy_q  <= 1'b1;
                        state_q <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_q     <= '0;
                        hilo_we_q <= 1'b1;
                        state_q   <= MD_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    busy_q    <= 1'b0;
                    hilo_we_q <= 1'b0;
                    state_q   <= MD_IDLE;
                end
                default: begin
                    cnt_q     <= '0;
                    busy_q    <= 1'b0;
                    hilo_we_q <= 1'b0;
                    state_q   <= MD_IDLE;
                end
            endcase
        end
    end

    assign md_busy_o = busy_q;
    assign hilo_we_o = hilo_we_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : 5-stage MIPS hazard unit: bypass selects, load-use / branch /
//               HI/LO stalls, and the MULT/DIV sequencer instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  wire logic    clk,
    input  wire logic    rst,
    hazard_ctrl_if.slave hz
);

    logic       md_busy;
    logic       hilo_we;
    logic       lwstall, brstall, mdstall, hazard;
    logic [1:0] fwd_ae, fwd_be;
    logic       fwd_ad, fwd_bd;

    md_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_sequencer (
        .clk        (clk),
        .rst        (rst),
        .md_start_i (hz.md_startE),
        .md_div_i   (hz.md_divE),
        .md_busy_o  (md_busy),
        .hilo_we_o  (hilo_we)
    );

    // Bypass selects and stall terms; $0 is excluded from bypass only, the
    // stall terms deliberately stay conservative.
    always_comb begin
        fwd_ae  = fwd_sel(hz.rsE, hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW);
        fwd_be  = fwd_sel(hz.rtE, hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW);
        fwd_ad  = (hz.rsD != REG_ZERO) && hz.regwriteM && (hz.writeregM == hz.rsD);
        fwd_bd  = (hz.rtD != REG_ZERO) && hz.regwriteM && (hz.writeregM == hz.rtD);
        lwstall = hz.memtoregE && ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
        brstall = hz.branchD &&
                  ((hz.regwriteE && ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
                   (hz.memtoregM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
        mdstall = hz.md_useD && (md_busy || hz.md_startE);
        hazard  = lwstall || brstall || mdstall;
    end

    // While reset is held the pipeline is frozen open with a bubble in E
    assign hz.stallF    = rst && hazard;
    assign hz.stallD    = rst && hazard;
    assign hz.flushE    = !rst || hazard;
    assign hz.forwardAE = rst ? fwd_ae : FWD_RF;
    assign hz.forwardBE = rst ? fwd_be : FWD_RF;
    assign hz.forwardAD = rst && fwd_ad;
    assign hz.forwardBD = rst && fwd_bd;
    assign hz.md_busy   = md_busy;
    assign hz.hilo_we   = hilo_we;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl: directed scenarios followed
//               by random traffic, compared against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    typedef struct packed {
        logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
        logic       rwE, rwM, rwW, mtrE, mtrM, br, mduse, start, div, rst_n;
    } stim_t;

    typedef struct packed {
        logic       stall, flush, fad, fbd;
        logic [1:0] fae, fbe;
        logic       busy, hilo;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    // Model of the HI/LO unit as "operation started in cycle t0, lasting n"
    int   cyc     = 0;
    bit   md_act  = 1'b0;
    int   md_t0   = 0;
    int   md_n    = 0;

    function automatic stim_t nop();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] r, input stim_t s);
        if (r == 5'd0)                 return 2'b00;
        if (s.rwM && s.wrM == r)       return 2'b10;
        if (s.rwW && s.wrW == r)       return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        logic lw, brs, hz, busy_e, hilo_e, idle;
        rst           = s.rst_n;
        hif.rsD       = s.rsD;   hif.rtD       = s.rtD;
        hif.rsE       = s.rsE;   hif.rtE       = s.rtE;
        hif.writeregE = s.wrE;   hif.writeregM = s.wrM;   hif.writeregW = s.wrW;
        hif.regwriteE = s.rwE;   hif.regwriteM = s.rwM;   hif.regwriteW = s.rwW;
        hif.memtoregE = s.mtrE;  hif.memtoregM = s.mtrM;
        hif.branchD   = s.br;    hif.md_useD   = s.mduse;
        hif.md_startE = s.start; hif.md_divE   = s.div;

        busy_e = md_act && (cyc > md_t0) && (cyc <= md_t0 + md_n);
        hilo_e = md_act && (cyc == md_t0 + md_n);
        idle   = !md_act || (cyc > md_t0 + md_n);

        lw  = s.mtrE && (s.rtE == s.rsD || s.rtE == s.rtD);
        brs = s.br && ((s.rwE && (s.wrE == s.rsD || s.wrE == s.rtD)) ||
                       (s.mtrM && (s.wrM == s.rsD || s.wrM == s.rtD)));
        hz  = lw || brs || (s.mduse && (busy_e || s.start));

        e      = '0;
        e.busy = busy_e;
        e.hilo = hilo_e;
        if (!s.rst_n) begin
            e.flush = 1'b1;
        end else begin
            e.stall = hz;
            e.flush = hz;
            e.fae   = ref_fwd(s.rsE, s);
            e.fbe   = ref_fwd(s.rtE, s);
            e.fad   = (s.rsD != 0) && s.rwM && (s.wrM == s.rsD);
            e.fbd   = (s.rtD != 0) && s.rwM && (s.wrM == s.rtD);
        end
        sb.push_back(e);

        if (!s.rst_n) begin
            md_act = 1'b0;
        end else if (s.start && idle) begin
            md_act = 1'b1;
            md_t0  = cyc;
            md_n   = s.div ? DIV_N : MULT_N;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc - 1);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation is checked mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stallF",    {1'b0, hif.stallF},    {1'b0, e.stall});
            chk("stallD",    {1'b0, hif.stallD},    {1'b0, e.stall});
            chk("flushE",    {1'b0, hif.flushE},    {1'b0, e.flush});
            chk("forwardAD", {1'b0, hif.forwardAD}, {1'b0, e.fad});
            chk("forwardBD", {1'b0, hif.forwardBD}, {1'b0, e.fbd});
            chk("forwardAE", hif.forwardAE,         e.fae);
            chk("forwardBE", hif.forwardBE,         e.fbe);
            chk("md_busy",   {1'b0, hif.md_busy},   {1'b0, e.busy});
            chk("hilo_we",   {1'b0, hif.hilo_we},   {1'b0, e.hilo});
        end
    end

    initial begin
        stim_t s;
        int    w;
        s = nop();
        s.rst_n = 1'b0;
        // First edge brings the registers out of their power-up state
        rst = 1'b0;
        hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
        hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
        hif.regwriteE = 1'b0; hif.regwriteM = 1'b0; hif.regwriteW = 1'b0;
        hif.memtoregE = 1'b0; hif.memtoregM = 1'b0; hif.branchD = 1'b0;
        hif.md_useD = 1'b0; hif.md_startE = 1'b0; hif.md_divE = 1'b0;
        @(posedge clk);
        #1;
        drive(s);
        drive(s);

        // ALU RAW: M over W, then W only, then $0
        s = nop(); s.rwM = 1; s.wrM = 8; s.rsE = 8; s.rwW = 1; s.wrW = 8; drive(s);
        s.wrM = 9;                                                         drive(s);
        s.rsE = 0; s.wrM = 0; s.wrW = 0;                                   drive(s);

        // Load-use stall, then bypass from M
        s = nop(); s.mtrE = 1; s.rtE = 9; s.rsD = 9;                       drive(s);
        s = nop(); s.mtrM = 1; s.rwM = 1; s.wrM = 9; s.rsE = 9;            drive(s);

        // Branch compare in D
        s = nop(); s.br = 1; s.rsD = 4; s.rwE = 1; s.wrE = 4;              drive(s);
        s = nop(); s.br = 1; s.rsD = 4; s.rwM = 1; s.wrM = 4;              drive(s);
        s.mtrM = 1;                                                        drive(s);

        // MULT then dependent MFLO
        s = nop(); s.start = 1; s.mduse = 1;                               drive(s);
        s.start = 0;
        repeat (7) drive(s);

        // DIV with independent traffic behind it
        s = nop(); s.start = 1; s.div = 1;                                 drive(s);
        s.start = 0;
        repeat (DIV_N + 2) drive(s);

        // Reset mid-DIV, then a fresh MULT
        s = nop(); s.start = 1; s.div = 1;                                 drive(s);
        s.start = 0;
        repeat (9) drive(s);
        s.rst_n = 0; s.mduse = 1;                                          drive(s);
        s = nop();
        repeat (DIV_N + 4) drive(s);
        s.start = 1;                                                       drive(s);
        s.start = 0;
        repeat (MULT_N + 2) drive(s);

        // Random traffic over a small register range to provoke matches
        repeat (3000) begin
            s.rsD   = 5'($urandom_range(0, 3));
            s.rtD   = 5'($urandom_range(0, 3));
            s.rsE   = 5'($urandom_range(0, 3));
            s.rtE   = 5'($urandom_range(0, 3));
            s.wrE   = 5'($urandom_range(0, 3));
            s.wrM   = 5'($urandom_range(0, 3));
            s.wrW   = 5'($urandom_range(0, 3));
            s.rwE   = 1'($urandom);
            s.rwM   = 1'($urandom);
            s.rwW   = 1'($urandom);
            s.mtrE  = 1'($urandom_range(0, 3) == 0);
            s.mtrM  = 1'($urandom_range(0, 3) == 0);
            s.br    = 1'($urandom_range(0, 3) == 0);
            s.mduse = 1'($urandom_range(0, 3) == 0);
            s.start = 1'($urandom_range(0, 15) == 0);
            s.div   = 1'($urandom);
            s.rst_n = 1'($urandom_range(0, 149) != 0);
            drive(s);
        end
        s = nop();
        drive(s);

        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
